// File: rtl/sdp_x_core_triosy_seq.sv
// Run-enable sequencer for the SDP X-core multiply stage: one beat per enabled cycle,
// layer beat counting and end-of-layer config triosy pulses. Optional SDP_X_CORE_SEQ_PERF_EN adds stall_cnt.
module sdp_x_core_triosy_seq #(
    parameter int NUM_CFG = 4,
    parameter int LEN_W   = 16
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               op_en,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               chn_in_pvld,
    output logic               chn_in_prdy,
    output logic               chn_out_pvld,
    input  logic               chn_out_prdy,
    output logic               core_wen,
    output logic               core_wten,
    output logic [NUM_CFG-1:0] cfg_triosy_lz,
    output logic               op_done,
`ifdef SDP_X_CORE_SEQ_PERF_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic [1:0]         dbg_state_o
);

    // Handshake: a beat moves when chn_in_pvld & chn_in_prdy at the clock edge; the output
    // register hands a beat downstream when chn_out_pvld & chn_out_prdy at the clock edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_cnt_q;
    logic             op_en_d_q;
    logic             out_pvld_q;
    logic             wten_q;
    logic             start;
    logic             last_beat;

    assign start     = (state_q == IDLE) & op_en & ~op_en_d_q;
    assign last_beat = (beat_cnt_q == {1'b0, len_q});
    assign core_wen  = (state_q == RUN) & chn_in_pvld & (~out_pvld_q | chn_out_prdy);

    assign chn_in_prdy   = core_wen;
    assign chn_out_pvld  = out_pvld_q;
    assign core_wten     = wten_q;
    assign cfg_triosy_lz = {NUM_CFG{core_wen & last_beat}};
    assign op_done       = (state_q == DONE);
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (core_wen & last_beat) state_d = DRAIN;
            DRAIN:   if (~out_pvld_q | chn_out_prdy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            op_en_d_q  <= 1'b0;
            out_pvld_q <= 1'b0;
            wten_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_en_d_q <= op_en;
            wten_q    <= ~core_wen;
            if (start) begin
                len_q      <= cfg_len;
                beat_cnt_q <= '0;
            end else if (core_wen) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            // A new beat overwrites the register even when the old one leaves in the same cycle.
            if (core_wen) begin
                out_pvld_q <= 1'b1;
            end else if (chn_out_prdy) begin
                out_pvld_q <= 1'b0;
            end
        end
    end

`ifdef SDP_X_CORE_SEQ_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_q <= '0;
        end else if (start) begin
            stall_q <= '0;
        end else if ((state_q == RUN) & chn_in_pvld & ~core_wen & (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sdp_x_core_triosy_seq.sv
// Directed bench for sdp_x_core_triosy_seq: reset, single-beat, streaming, backpressure,
// restart guard and mid-layer reset, checked with immediate assertions.
module tb_sdp_x_core_triosy_seq;

    logic        clk;
    logic        rstn;
    logic        op_en;
    logic [15:0] cfg_len;
    logic        in_pvld;
    logic        in_prdy;
    logic        out_pvld;
    logic        out_prdy;
    logic        wen;
    logic        wten;
    logic [3:0]  lz;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef SDP_X_CORE_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    sdp_x_core_triosy_seq #(.NUM_CFG(4), .LEN_W(16)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .op_en           (op_en),
        .cfg_len         (cfg_len),
        .chn_in_pvld     (in_pvld),
        .chn_in_prdy     (in_prdy),
        .chn_out_pvld    (out_pvld),
        .chn_out_prdy    (out_prdy),
        .core_wen        (wen),
        .core_wten       (wten),
        .cfg_triosy_lz   (lz),
        .op_done         (done),
`ifdef SDP_X_CORE_SEQ_PERF_EN
        .stall_cnt       (stall_cnt),
`endif
        .dbg_state_o     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // From IDLE: make op_en low for one edge, then present the rising edge.
    // Returns in the first RUN cycle.
    task automatic start_layer(input logic [15:0] len);
        op_en   = 1'b0;
        cfg_len = len;
        step();
        op_en = 1'b1;
        step();
    endtask

    logic exp_wen  [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
    logic exp_pvld [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic exp_wten [10] = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 1};

    initial begin
        int n_wen, n_lz, n_done, n_beats;

        rstn     = 1'b0;
        op_en    = 1'b0;
        cfg_len  = 16'd0;
        in_pvld  = 1'b0;
        out_prdy = 1'b0;
        step();
        step();
        #1;
        chk("rst_state", dbg_state, 0);
        chk("rst_pvld", out_pvld, 0);
        chk("rst_wten", wten, 1);
        chk("rst_lz", lz, 0);
        chk("rst_done", done, 0);
`ifdef SDP_X_CORE_SEQ_PERF_EN
        chk("rst_stall", stall_cnt, 0);
`endif
        rstn = 1'b1;
        step();

        // Single-beat layer
        in_pvld  = 1'b1;
        out_prdy = 1'b1;
        start_layer(16'd0);
        #1;
        chk("one_state_run", dbg_state, 1);
        chk("one_wen", wen, 1);
        chk("one_prdy", in_prdy, 1);
        chk("one_lz", lz, 4'hF);
        chk("one_wten_c0", wten, 1);
        step();
        #1;
        chk("one_state_drain", dbg_state, 2);
        chk("one_wen_c1", wen, 0);
        chk("one_pvld_c1", out_pvld, 1);
        chk("one_wten_c1", wten, 0);
        chk("one_done_c1", done, 0);
        step();
        #1;
        chk("one_done_c2", done, 1);
        chk("one_pvld_c2", out_pvld, 0);
        step();
        #1;
        chk("one_done_c3", done, 0);
        chk("one_state_idle", dbg_state, 0);

        // Streaming, cfg_len=7
        start_layer(16'd7);
        n_wen = 0; n_lz = 0; n_done = 0; n_beats = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c < 8) begin
                chk("strm_wen", wen, 1);
                chk("strm_lz", lz, (c == 7) ? 4'hF : 4'h0);
            end
            n_wen   += int'(wen);
            n_lz    += int'(lz == 4'hF);
            n_done  += int'(done);
            n_beats += int'(out_pvld & out_prdy);
            step();
        end
        chk("strm_n_wen", n_wen, 8);
        chk("strm_n_lz", n_lz, 1);
        chk("strm_n_done", n_done, 1);
        chk("strm_n_beats", n_beats, 8);

        // Backpressure, cfg_len=3, prdy low for RUN cycles 2..5
        start_layer(16'd3);
        n_beats = 0;
        for (int c = 0; c < 10; c++) begin
            out_prdy = !(c >= 2 && c <= 5);
            #1;
            chk("bp_wen", wen, exp_wen[c]);
            chk("bp_pvld", out_pvld, exp_pvld[c]);
            chk("bp_wten", wten, exp_wten[c]);
            chk("bp_lz", lz, (c == 7) ? 4'hF : 4'h0);
            chk("bp_done", done, (c == 9));
            n_beats += int'(out_pvld & out_prdy);
            step();
        end
        chk("bp_n_beats", n_beats, 4);
`ifdef SDP_X_CORE_SEQ_PERF_EN
        chk("bp_stall_cnt", stall_cnt, 4);
`endif

        // Restart guard: op_en held high across DONE must not start a layer
        out_prdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("guard_state", dbg_state, 0);
            chk("guard_wen", wen, 0);
            step();
        end
        start_layer(16'd2);
        op_en   = 1'b0;
        cfg_len = 16'd9;
        n_wen = 0; n_done = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rs_lz", lz, (c == 2) ? 4'hF : 4'h0);
            chk("rs_done", done, (c == 4));
            n_wen += int'(wen);
            step();
        end
        chk("rs_n_wen", n_wen, 3);

        // Reset mid-stream after five beats of an 11-beat layer
        start_layer(16'd10);
        n_wen = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_wen += int'(wen);
            step();
        end
        chk("mid_n_wen", n_wen, 5);
        rstn  = 1'b0;
        op_en = 1'b0;
        #1;
        chk("mid_state", dbg_state, 0);
        chk("mid_pvld", out_pvld, 0);
        chk("mid_wten", wten, 1);
        chk("mid_wen", wen, 0);
        chk("mid_lz", lz, 0);
        chk("mid_done", done, 0);
        step();
        rstn = 1'b1;
        step();
        step();
        #1;
        chk("mid_idle_after", dbg_state, 0);
        chk("mid_wen_after", wen, 0);
        op_en = 1'b1;
        step();
        #1;
        chk("mid_restart", dbg_state, 1);
        chk("mid_restart_wen", wen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
